// File: rtl/systolic_pkg.sv
// Shared types for the systolic tile: FSM states, tagged operand beat, flush-length helper.
// Latency: none (types and constant functions only).
// Backpressure: none.
package systolic_pkg;

   // Widest operand a beat can carry; narrower operands are zero-extended into it.
   localparam int BEAT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // One operand travelling through the array together with its valid tag.
   typedef struct packed {
      logic              valid;
      logic [BEAT_W-1:0] data;
   } beat_t;

   // Cycles needed after the last accepted beat for it to reach the far corner PE.
   function automatic int flush_len(input int rows, input int cols);
      return rows + cols - 1;
   endfunction

endpackage

// File: rtl/systolic_pe.sv
// Multiply-accumulate cell: accumulates a*b when both operand tags are valid, forwards A right and B down.
// Latency: operands reappear on o_a/o_b one cycle later; o_acc updates on the accepting edge.
// Backpressure: none; the cell consumes whatever arrives each cycle.
module systolic_pe
   import systolic_pkg::*;
#(
   parameter int OUTWIDTH = 12
) (
   input  logic                i_clk,
   input  logic                i_arst,
   input  logic                i_clr,
   input  beat_t               i_a,
   input  beat_t               i_b,
   output beat_t               o_a,
   output beat_t               o_b,
`ifdef SYSTOLIC_TILE_SATURATE_EN
   output logic                o_sat,
`endif
   output logic [OUTWIDTH-1:0] o_acc
);

   beat_t               r_a;
   beat_t               r_b;
   logic [OUTWIDTH-1:0] r_acc;
   logic                w_mac;

   assign w_mac = i_a.valid && i_b.valid;

   // Pass both operands (with tags) one hop onward.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_a <= '0;
         r_b <= '0;
      end else begin
         r_a <= i_a;
         r_b <= i_b;
      end
   end

`ifdef SYSTOLIC_TILE_SATURATE_EN
   logic                r_sat;
   logic [OUTWIDTH:0]   w_sum;

   assign w_sum = {1'b0, r_acc} + (OUTWIDTH+1)'(i_a.data * i_b.data);

   // Clear on start, otherwise accumulate and clamp at all-ones, remembering any clamp.
   always_ff @(posedge i_clk) begin
      if (i_arst || i_clr) begin
         r_acc <= '0;
         r_sat <= 1'b0;
      end else if (w_mac) begin
         if (w_sum[OUTWIDTH]) begin
            r_acc <= '1;
            r_sat <= 1'b1;
         end else begin
            r_acc <= w_sum[OUTWIDTH-1:0];
         end
      end
   end

   assign o_sat = r_sat;
`else
   // Clear on start, otherwise accumulate modulo 2^OUTWIDTH.
   always_ff @(posedge i_clk) begin
      if (i_arst || i_clr) begin
         r_acc <= '0;
      end else if (w_mac) begin
         r_acc <= r_acc + OUTWIDTH'(i_a.data * i_b.data);
      end
   end
`endif

   assign o_a   = r_a;
   assign o_b   = r_b;
   assign o_acc = r_acc;

endmodule

// File: rtl/systolic_tile.sv
// ROWSxCOLS output-stationary systolic tile computing C = A*B from k operand beats (SYSTOLIC_TILE_SATURATE_EN adds clamping and o_sat).
// Latency: o_done pulses in the ROWS+COLS-th cycle after the edge accepting the last beat; k=0 completes the cycle after start.
// Backpressure: o_ready is high only in LOAD; cycles without i_valid inject bubbles, other states accept nothing.
module systolic_tile
   import systolic_pkg::*;
#(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int BITWIDTH = 4,
   parameter int OUTWIDTH = 12,
   parameter int KWIDTH   = 8
) (
   input  logic                          i_clk,
   input  logic                          i_arst,
   input  logic                          i_start,
   input  logic [KWIDTH-1:0]             i_k,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [ROWS*BITWIDTH-1:0]      i_row,
   input  logic [COLS*BITWIDTH-1:0]      i_col,
   output logic                          o_busy,
   output logic                          o_done,
`ifdef SYSTOLIC_TILE_SATURATE_EN
   output logic                          o_sat,
`endif
   output logic [ROWS*COLS*OUTWIDTH-1:0] o_c
);

   localparam int FLUSH_LEN = flush_len(ROWS, COLS);
   localparam int FLW       = $clog2(FLUSH_LEN + 1);

   state_e              r_state;
   logic [KWIDTH-1:0]   r_k;
   logic [KWIDTH-1:0]   r_beat;
   logic [FLW-1:0]      r_flush;
   logic                w_start;
   logic                w_accept;
   beat_t               w_a [ROWS][COLS];
   beat_t               w_b [ROWS][COLS];
   logic [ROWS*COLS-1:0] w_sat;

   assign w_start  = (r_state == ST_IDLE) && i_start;
   assign w_accept = (r_state == ST_LOAD) && i_valid;
   assign o_ready  = (r_state == ST_LOAD);
   assign o_busy   = (r_state != ST_IDLE);
   assign o_done   = (r_state == ST_DONE);

   // Control FSM: count accepted beats, then drain the array before signalling done.
   always_ff @(posedge i_clk) begin
      if (i_arst) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_beat  <= '0;
         r_flush <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_k     <= i_k;
                  r_beat  <= '0;
                  r_state <= (i_k == '0) ? ST_DONE : ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  if (r_beat == r_k - KWIDTH'(1)) begin
                     r_flush <= '0;
                     r_state <= ST_FLUSH;
                  end else begin
                     r_beat <= r_beat + KWIDTH'(1);
                  end
               end
            end
            ST_FLUSH: begin
               if (r_flush == FLW'(FLUSH_LEN - 1)) begin
                  r_state <= ST_DONE;
               end else begin
                  r_flush <= r_flush + FLW'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Row lane i enters column 0 after i cycles of skew.
   for (genvar i = 0; i < ROWS; i++) begin : g_rskew
      beat_t w_in;
      assign w_in = {w_accept, BEAT_W'(i_row[i*BITWIDTH +: BITWIDTH])};
      if (i == 0) begin : g_d0
         assign w_a[i][0] = w_in;
      end else begin : g_dn
         beat_t r_sh [0:i-1];
         // Shift the tagged operand through i delay stages.
         always_ff @(posedge i_clk) begin
            if (i_arst) begin
               for (int d = 0; d < i; d++) r_sh[d] <= '0;
            end else begin
               r_sh[0] <= w_in;
               for (int d = 1; d < i; d++) r_sh[d] <= r_sh[d-1];
            end
         end
         assign w_a[i][0] = r_sh[i-1];
      end
   end

   // Column lane j enters row 0 after j cycles of skew.
   for (genvar j = 0; j < COLS; j++) begin : g_cskew
      beat_t w_in;
      assign w_in = {w_accept, BEAT_W'(i_col[j*BITWIDTH +: BITWIDTH])};
      if (j == 0) begin : g_d0
         assign w_b[0][j] = w_in;
      end else begin : g_dn
         beat_t r_sh [0:j-1];
         // Shift the tagged operand through j delay stages.
         always_ff @(posedge i_clk) begin
            if (i_arst) begin
               for (int d = 0; d < j; d++) r_sh[d] <= '0;
            end else begin
               r_sh[0] <= w_in;
               for (int d = 1; d < j; d++) r_sh[d] <= r_sh[d-1];
            end
         end
         assign w_b[0][j] = r_sh[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         beat_t               w_a_out;
         beat_t               w_b_out;
         logic [OUTWIDTH-1:0] w_acc;
         logic                w_pe_sat;

         systolic_pe #(
            .OUTWIDTH(OUTWIDTH)
         ) u_pe (
            .i_clk (i_clk),
            .i_arst(i_arst),
            .i_clr (w_start),
            .i_a   (w_a[i][j]),
            .i_b   (w_b[i][j]),
            .o_a   (w_a_out),
            .o_b   (w_b_out),
`ifdef SYSTOLIC_TILE_SATURATE_EN
            .o_sat (w_pe_sat),
`endif
            .o_acc (w_acc)
         );

`ifndef SYSTOLIC_TILE_SATURATE_EN
         assign w_pe_sat = 1'b0;
`endif
         assign w_sat[i*COLS+j] = w_pe_sat;
         assign o_c[(i*COLS+j)*OUTWIDTH +: OUTWIDTH] = w_acc;

         if (j == COLS-1) begin : g_aend
            beat_t w_unused_a;
            assign w_unused_a = w_a_out;
         end else begin : g_afwd
            assign w_a[i][j+1] = w_a_out;
         end

         if (i == ROWS-1) begin : g_bend
            beat_t w_unused_b;
            assign w_unused_b = w_b_out;
         end else begin : g_bfwd
            assign w_b[i+1][j] = w_b_out;
         end
      end
   end

`ifdef SYSTOLIC_TILE_SATURATE_EN
   assign o_sat = |w_sat;
`else
   logic w_unused_sat;
   assign w_unused_sat = |w_sat;
`endif

endmodule

// File: tb/tb_systolic_tile.sv
// Self-checking bench for systolic_tile: scoreboard of expected C matrices, checked at each o_done.
// Latency: checks o_done in the ROWS+COLS-th cycle after the last accepted beat.
// Backpressure: drives i_valid held or toggling and only counts beats seen with o_ready high.
module tb_systolic_tile;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int BW = 4;
   localparam int OW = 12;
   localparam int KW = 8;

   logic              clk = 1'b0;
   logic              arst;
   logic              start;
   logic [KW-1:0]     k_in;
   logic              valid;
   logic              ready;
   logic [R*BW-1:0]   row;
   logic [C*BW-1:0]   col;
   logic              busy;
   logic              done;
   logic [R*C*OW-1:0] c_out;
`ifdef SYSTOLIC_TILE_SATURATE_EN
   logic              sat;
   bit                exp_sat_q[$];
`endif

   int                n_vec = 0;
   int                n_err = 0;
   logic [R*BW-1:0]   a_bt [32];
   logic [C*BW-1:0]   b_bt [32];
   logic [R*C*OW-1:0] exp_q[$];
   logic [R*C*OW-1:0] zero_c = '0;

   always #5 clk = ~clk;

   systolic_tile #(
      .ROWS(R), .COLS(C), .BITWIDTH(BW), .OUTWIDTH(OW), .KWIDTH(KW)
   ) dut (
      .i_clk  (clk),
      .i_arst (arst),
      .i_start(start),
      .i_k    (k_in),
      .i_valid(valid),
      .o_ready(ready),
      .i_row  (row),
      .i_col  (col),
      .o_busy (busy),
      .o_done (done),
`ifdef SYSTOLIC_TILE_SATURATE_EN
      .o_sat  (sat),
`endif
      .o_c    (c_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_c(input string tag, input logic [R*C*OW-1:0] exp);
      for (int i = 0; i < R; i++)
         for (int j = 0; j < C; j++)
            check($sformatf("%s c[%0d][%0d]", tag, i, j),
                  64'(c_out[(i*C+j)*OW +: OW]), 64'(exp[(i*C+j)*OW +: OW]));
   endtask

   // kind 0: identity A with B all 3; kind 1: everything 15; kind 2: random
   task automatic set_operands(input int kind, input int k);
      for (int kk = 0; kk < k; kk++) begin
         for (int i = 0; i < R; i++)
            a_bt[kk][i*BW +: BW] = (kind == 0) ? ((i == kk) ? 4'd1 : 4'd0) :
                                   (kind == 1) ? 4'd15 : 4'($urandom_range(0, 15));
         for (int j = 0; j < C; j++)
            b_bt[kk][j*BW +: BW] = (kind == 0) ? 4'd3 :
                                   (kind == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      end
   endtask

   task automatic push_expect(input int k);
      logic [R*C*OW-1:0] e = '0;
      bit                s = 1'b0;
      for (int i = 0; i < R; i++) begin
         for (int j = 0; j < C; j++) begin
            longint acc = 0;
            for (int kk = 0; kk < k; kk++) begin
               int av = int'(a_bt[kk][i*BW +: BW]);
               int bv = int'(b_bt[kk][j*BW +: BW]);
               acc += av * bv;
            end
`ifdef SYSTOLIC_TILE_SATURATE_EN
            if (acc > (1 << OW) - 1) begin
               acc = (1 << OW) - 1;
               s   = 1'b1;
            end
`else
            acc = acc % (1 << OW);
`endif
            e[(i*C+j)*OW +: OW] = OW'(acc);
         end
      end
      exp_q.push_back(e);
`ifdef SYSTOLIC_TILE_SATURATE_EN
      exp_sat_q.push_back(s);
`else
      if (s) $display("note: unexpected saturation flag in wrap model");
`endif
   endtask

   task automatic run_product(input string tag, input int k, input bit toggle,
                              input int poke_beat, input bit restart_in_done);
      int                sent = 0;
      int                guard = 0;
      int                load_cyc = 0;
      int                cyc;
      int                extra = 0;
      bit                v = 1'b1;
      logic              rdy_flush = 1'b0;
      logic [R*C*OW-1:0] e;
      push_expect(k);
      @(negedge clk);
      start = 1'b1;
      k_in  = KW'(k);
      @(negedge clk);
      start = 1'b0;
      while (sent < k && guard < 200) begin
         valid = v;
         row   = a_bt[sent];
         col   = b_bt[sent];
         if (sent == poke_beat) begin
            start = 1'b1;
            k_in  = '0;
         end else begin
            start = 1'b0;
         end
         if (ready === 1'b1) load_cyc++;
         if (v && ready === 1'b1) sent++;
         if (toggle) v = !v;
         @(negedge clk);
         guard++;
      end
      // keep offering junk beats while the array drains
      start = 1'b0;
      valid = 1'b1;
      row   = '1;
      col   = '1;
      cyc   = 1;
      while (done !== 1'b1 && cyc < 100) begin
         rdy_flush |= ready;
         @(negedge clk);
         cyc++;
      end
      valid = 1'b0;
      check({tag, " load_cycles"}, 64'(load_cyc), toggle ? 64'(2*k-1) : 64'(k));
      check({tag, " ready_in_flush"}, 64'(rdy_flush), 64'd0);
      check({tag, " done_latency"}, 64'(cyc), 64'(R + C));
      check({tag, " busy_at_done"}, 64'(busy), 64'd1);
      e = exp_q.pop_front();
      check_c(tag, e);
`ifdef SYSTOLIC_TILE_SATURATE_EN
      check({tag, " sat"}, 64'(sat), 64'(exp_sat_q.pop_front()));
`endif
      if (restart_in_done) begin
         start = 1'b1;
         k_in  = KW'(k);
      end
      @(negedge clk);
      start = 1'b0;
      check({tag, " done_pulse"}, 64'(done), 64'd0);
      check({tag, " idle_after"}, 64'(busy), 64'd0);
      if (restart_in_done) begin
         for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
         end
         check({tag, " second_done"}, 64'(extra), 64'd0);
         check({tag, " still_idle"}, 64'(busy), 64'd0);
         check_c({tag, " hold"}, e);
      end
   endtask

   initial begin
      arst  = 1'b1;
      start = 1'b0;
      valid = 1'b0;
      k_in  = '0;
      row   = '0;
      col   = '0;
      repeat (3) @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst ready", 64'(ready), 64'd0);
      check_c("rst", zero_c);
`ifdef SYSTOLIC_TILE_SATURATE_EN
      check("rst sat", 64'(sat), 64'd0);
`endif
      arst = 1'b0;
      @(negedge clk);

      set_operands(0, 4);
      run_product("ident", 4, 1'b0, -1, 1'b0);

      set_operands(0, 4);
      run_product("toggle", 4, 1'b1, -1, 1'b0);

      set_operands(1, 20);
      run_product("all15", 20, 1'b0, -1, 1'b0);

      set_operands(2, 6);
      run_product("rand_a", 6, 1'b1, -1, 1'b0);

      set_operands(2, 9);
      run_product("rand_b", 9, 1'b0, -1, 1'b0);

      // k = 0: immediate completion with a cleared result
      push_expect(0);
      @(negedge clk);
      start = 1'b1;
      k_in  = '0;
      @(negedge clk);
      start = 1'b0;
      check("k0 done", 64'(done), 64'd1);
      check("k0 ready", 64'(ready), 64'd0);
      check_c("k0", exp_q.pop_front());
`ifdef SYSTOLIC_TILE_SATURATE_EN
      check("k0 sat", 64'(sat), 64'(exp_sat_q.pop_front()));
`endif
      @(negedge clk);
      check("k0 done_pulse", 64'(done), 64'd0);
      check("k0 ready_after", 64'(ready), 64'd0);
      check("k0 idle", 64'(busy), 64'd0);

      // reset after two of four beats discards the product
      set_operands(0, 4);
      @(negedge clk);
      start = 1'b1;
      k_in  = 8'd4;
      @(negedge clk);
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         valid = 1'b1;
         row   = a_bt[b];
         col   = b_bt[b];
         @(negedge clk);
      end
      valid = 1'b0;
      arst  = 1'b1;
      @(negedge clk);
      arst  = 1'b0;
      check("abort busy", 64'(busy), 64'd0);
      check("abort ready", 64'(ready), 64'd0);
      check_c("abort", zero_c);
      run_product("post_abort", 4, 1'b0, -1, 1'b0);

      // starts during LOAD and during DONE are ignored
      set_operands(0, 4);
      run_product("ignore_start", 4, 1'b0, 1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
      $fatal(1);
   end

endmodule
